// File: rtl/counter_cmd_pkg.sv
// counter_cmd_pkg: shared width, repeat-FSM state encoding and timer sizing
// for the counter command generator.
`default_nettype none

package counter_cmd_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed for a down-counter that starts at cycles-1.
  function automatic int timer_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, consecutive-sample debouncer and
// registered press/release strobes for one raw push-button.
`default_nettype none

module btn_conditioner
  import counter_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              DB_W    = timer_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic            stable;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '0;
      stable        <= 1'b0;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], btn};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync[1] == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        // This is the DEBOUNCE_CYCLES-th differing sample in a row.
        db_cnt        <= '0;
        stable        <= sync[1];
        press_pulse   <= sync[1];
        release_pulse <= ~sync[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_cmd_gen.sv
// counter_cmd_gen: turns UP/DOWN/LOAD buttons and switches into arbitrated,
// registered one-cycle counter commands with limit-aware auto-repeat.
`default_nettype none

module counter_cmd_gen
  import counter_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_UP,
  input  logic             BTN_DN,
  input  logic             BTN_LD,
  input  logic [CNT_W-1:0] SW,
  input  logic             HIGH,
  input  logic             LOW,
  output logic [CNT_W-1:0] IN,
  output logic             load,
  output logic             UP,
  output logic             Down
);

  localparam int TMR_W = timer_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

  // Index 0 is the UP channel, index 1 the DOWN channel.
  logic [1:0]       press;
  logic [1:0]       rel;
  logic             ld_press;
  logic             ld_release_unused;
  rpt_state_t       state [2];
  logic [TMR_W-1:0] timer [2];
  logic [1:0]       first_req;
  logic [1:0]       rpt_req;
  logic             up_req;
  logic             dn_req;
  logic [CNT_W-1:0] sw_meta;
  logic [CNT_W-1:0] sw_sync;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_up (
    .clk          (CLK),
    .rst_n        (RST),
    .btn          (BTN_UP),
    .press_pulse  (press[0]),
    .release_pulse(rel[0])
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dn (
    .clk          (CLK),
    .rst_n        (RST),
    .btn          (BTN_DN),
    .press_pulse  (press[1]),
    .release_pulse(rel[1])
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_ld (
    .clk          (CLK),
    .rst_n        (RST),
    .btn          (BTN_LD),
    .press_pulse  (ld_press),
    .release_pulse(ld_release_unused)
  );

  always_comb begin
    first_req = '0;
    rpt_req   = '0;
    for (int i = 0; i < 2; i++) begin
      first_req[i] = (state[i] == IDLE) && press[i];
      rpt_req[i]   = (state[i] != IDLE) && (timer[i] == '0) && !rel[i];
    end
  end

  // Limit masking drops only repeat slots; the press pulse always goes out.
  assign up_req = first_req[0] | (rpt_req[0] & ~HIGH);
  assign dn_req = first_req[1] | (rpt_req[1] & ~LOW);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rel[i]) begin
          state[i] <= IDLE;
        end else begin
          case (state[i])
            IDLE: begin
              if (press[i]) begin
                state[i] <= DELAY;
                timer[i] <= DELAY_LOAD;
              end
            end
            DELAY: begin
              if (timer[i] == '0) begin
                state[i] <= REPEAT;
                timer[i] <= RATE_LOAD;
              end else begin
                timer[i] <= timer[i] - 1'b1;
              end
            end
            REPEAT: begin
              if (timer[i] == '0) timer[i] <= RATE_LOAD;
              else                timer[i] <= timer[i] - 1'b1;
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Fixed priority load > Down > UP; losers are simply dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
      IN      <= '0;
      load    <= 1'b0;
      UP      <= 1'b0;
      Down    <= 1'b0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (ld_press) IN <= sw_sync;
      load <= ld_press;
      Down <= dn_req & ~ld_press;
      UP   <= up_req & ~ld_press & ~dn_req;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_gen.sv
// tb_counter_cmd_gen: directed scenarios plus random button traffic, checked
// every cycle against a time-based behavioural model of the command stage.
`default_nettype none

module tb_counter_cmd_gen;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BTN_UP = 1'b0, BTN_DN = 1'b0, BTN_LD = 1'b0;
  logic [4:0] SW = 5'd0;
  logic       HIGH = 1'b0, LOW = 1'b0;
  logic [4:0] IN;
  logic       load, UP, Down;

  always #5 CLK = ~CLK;

  counter_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN_UP(BTN_UP),
    .BTN_DN(BTN_DN),
    .BTN_LD(BTN_LD),
    .SW    (SW),
    .HIGH  (HIGH),
    .LOW   (LOW),
    .IN    (IN),
    .load  (load),
    .UP    (UP),
    .Down  (Down)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model (edge-indexed timeline) ----------------
  int         n = 0;
  int         t0 [3] = '{0, 0, 0};
  int         last_t [3] = '{-100, -100, -100};
  bit         stab [3] = '{0, 0, 0};
  logic [2:0] raw_h [8192];
  logic [4:0] sw_h [8192];
  logic       e_load = 1'b0, e_up = 1'b0, e_dn = 1'b0;
  logic [4:0] e_in = 5'd0;
  bit         ld_r, up_r, dn_r, all_diff;

  function automatic bit raw_at(input int j, input int b);
    if (j < 1) return 1'b0;
    return raw_h[j % 8192][b];
  endfunction

  function automatic logic [4:0] sw_at(input int j);
    if (j < 1) return 5'd0;
    return sw_h[j % 8192];
  endfunction

  function automatic bit rpt_slot(input int now, input int s);
    int d = now - s;
    return (s > 0) && (d >= RD) && (((d - RD) % RR) == 0);
  endfunction

  always @(posedge CLK) begin
    if (!RST) begin
      n = 0;
      for (int b = 0; b < 3; b++) begin
        t0[b] = 0; last_t[b] = -100; stab[b] = 1'b0;
      end
      e_load = 1'b0; e_up = 1'b0; e_dn = 1'b0; e_in = 5'd0;
    end else begin
      n++;
      raw_h[n % 8192] = {BTN_LD, BTN_DN, BTN_UP};
      sw_h[n % 8192]  = SW;
      ld_r = (t0[2] == n);
      up_r = (t0[0] == n) || (rpt_slot(n, t0[0]) && !HIGH);
      dn_r = (t0[1] == n) || (rpt_slot(n, t0[1]) && !LOW);
      e_load = ld_r;
      e_dn   = dn_r && !ld_r;
      e_up   = up_r && !ld_r && !dn_r;
      if (ld_r) e_in = sw_at(n - 2);
      // A button flips once its last DB synced samples (seen two edges late) all disagree.
      for (int b = 0; b < 3; b++) begin
        all_diff = (n >= last_t[b] + DB);
        for (int j = n - DB + 1; j <= n; j++)
          if (raw_at(j - 2, b) == stab[b]) all_diff = 1'b0;
        if (all_diff) begin
          stab[b]   = ~stab[b];
          last_t[b] = n;
          t0[b]     = stab[b] ? n + 1 : 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    check("load", load, RST ? e_load : 1'b0);
    check("up",   UP,   RST ? e_up   : 1'b0);
    check("down", Down, RST ? e_dn   : 1'b0);
    check("in",   IN,   RST ? e_in   : 5'd0);
    check("excl", (int'(load) + int'(UP) + int'(Down)) > 1, 0);
  end

  int cnt_up = 0, cnt_dn = 0, cnt_ld = 0;
  always @(posedge CLK) begin
    #2;
    cnt_up += int'(UP);
    cnt_dn += int'(Down);
    cnt_ld += int'(load);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic wait_for(input string tag, input int sel, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge CLK); #1;
      seen = (sel == 0) ? load : (sel == 1) ? UP : Down;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int         s_up, s_dn, s_ld, first, cnt, found;
  int         q[$];
  int         exp_q[$];
  logic [2:0] lvl, glitch;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_in",   IN,   5'd0);
    check("rst_load", load, 1'b0);
    check("rst_up",   UP,   1'b0);
    check("rst_down", Down, 1'b0);
    RST = 1'b1;
    tick(5);

    // Reset asserted while a load pulse is on the outputs
    SW = 5'h0B; BTN_LD = 1'b1;
    wait_for("t1_load_seen", 0, 20);
    #1 RST = 1'b0;
    #1;
    check("t1_rst_load", load, 1'b0);
    check("t1_rst_in",   IN,   5'd0);
    BTN_LD = 1'b0;
    tick(2);
    RST = 1'b1;
    s_up = cnt_up; s_dn = cnt_dn; s_ld = cnt_ld;
    tick(30);
    check("t1_quiet", (cnt_up - s_up) + (cnt_dn - s_dn) + (cnt_ld - s_ld), 0);

    // Bounce shorter than the debounce window, then a clean hold
    s_up = cnt_up;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i % 2 == 0) BTN_UP = ~BTN_UP;
    end
    tick(20);
    check("t2_bounce", cnt_up - s_up, 0);
    @(negedge CLK); BTN_UP = 1'b1;
    first = 0; cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLK); #1;
      if (UP) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check("t2_latency", first, DB + 3);
    check("t2_single",  cnt,   1);
    @(negedge CLK); BTN_UP = 1'b0;
    tick(20);

    // Held DOWN auto-repeat timeline
    @(negedge CLK); BTN_DN = 1'b1; LOW = 1'b0;
    q.delete();
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (Down) q.push_back(k);
    end
    @(negedge CLK); BTN_DN = 1'b0;
    exp_q.delete();
    exp_q.push_back(DB + 3);
    for (int t = DB + 3 + RD; t <= 40; t += RR) exp_q.push_back(t);
    check("t3_count", q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) check("t3_slot", q[i], exp_q[i]);
    tick(DB + 3);
    s_dn = cnt_dn;
    tick(20);
    check("t3_stopped", cnt_dn - s_dn, 0);

    // HIGH limit masks repeat UP pulses until it drops
    @(negedge CLK); BTN_UP = 1'b1; HIGH = 1'b0;
    wait_for("t4_first", 1, 20);
    @(negedge CLK); HIGH = 1'b1;
    s_up = cnt_up;
    tick(20);
    check("t4_masked", cnt_up - s_up, 0);
    HIGH = 1'b0;
    found = 0;
    for (int k = 0; k < RR; k++) begin
      @(posedge CLK); #1;
      if (UP) found = 1;
    end
    check("t4_resume", found, 1);
    @(negedge CLK); BTN_UP = 1'b0;
    tick(20);

    // LOAD captures switches once and holds
    SW = 5'b10110;
    tick(3);
    BTN_LD = 1'b1;
    s_ld = cnt_ld;
    wait_for("t5_load", 0, 20);
    check("t5_in", IN, 5'b10110);
    @(negedge CLK); SW = 5'b01001;
    tick(10);
    check("t5_hold", IN, 5'b10110);
    check("t5_once", cnt_ld - s_ld, 1);
    BTN_LD = 1'b0;
    tick(12);

    // Simultaneous presses, then UP and DOWN both held
    @(negedge CLK); BTN_LD = 1'b1; BTN_UP = 1'b1; BTN_DN = 1'b1;
    wait_for("t6_load", 0, 20);
    check("t6_no_up",   UP,   1'b0);
    check("t6_no_down", Down, 1'b0);
    @(negedge CLK); BTN_LD = 1'b0;
    s_up = cnt_up; s_dn = cnt_dn;
    tick(30);
    check("t6_up_lost",   cnt_up - s_up, 0);
    check("t6_down_wins", (cnt_dn - s_dn) > 0, 1);
    BTN_UP = 1'b0; BTN_DN = 1'b0;
    tick(20);

    // Random traffic with short glitches and wandering limit flags
    lvl = 3'b000;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 19) == 0) lvl[b] = ~lvl[b];
      glitch = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      {BTN_LD, BTN_DN, BTN_UP} = lvl ^ glitch;
      if ($urandom_range(0, 9) == 0) HIGH = ~HIGH;
      if ($urandom_range(0, 9) == 0) LOW = ~LOW;
      SW = 5'($urandom);
    end
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
